// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC slave front-end and the buffer stage behind it.
//   - default bus widths
//   - register address map seen on the FSMC address lines
//   - bus FSM state encoding
package fsmc_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 2;

    localparam logic [AW_DEFAULT-1:0] ADDR_DATA  = 2'd0;
    localparam logic [AW_DEFAULT-1:0] ADDR_INDEX = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_HOLD = 2'd3
    } fsmc_state_e;

endpackage

// File: rtl/fsmc_sync.sv
// N-stage synchroniser for one asynchronous strobe, with edge outputs.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   dout       : synchronised level (last stage)
//   fall, rise : single-cycle edge flags of dout
// Every stage, including the edge-history flop, resets to RST_VAL so a
// strobe that is already at its inactive level produces no edge after reset.
module fsmc_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] stg;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg  <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            stg  <= {stg[STAGES-2:0], din};
            prev <= stg[STAGES-1];
        end
    end

    assign dout = stg[STAGES-1];
    assign fall = prev & ~dout;
    assign rise = ~prev & dout;

endmodule

// File: rtl/fsmc_slave_if.sv
// FSMC bus front-end: synchronises nce/noe/nwe, captures address and data,
// issues single-cycle write/read strobes to the buffer stage, registers read
// data onto the pads and keeps sticky error flags plus transaction counters.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   nce, noe, nwe, addr  : asynchronous FSMC pins
//   data_in              : pad input side of the data bus
//   data_out, data_oe    : pad output value and output enable
//   wr_stb/wr_addr/wr_data : one-cycle write to the consumer
//   rd_stb/rd_addr       : one-cycle read request to the consumer
//   rd_data              : consumer read data, valid RD_LAT cycles after rd_stb
//   rd_done              : one-cycle pulse when nOE is released
//   err_overlap, err_abort : sticky protocol error flags
//   wr_count, rd_count   : completed transaction counters (wrap)
//
// state   | meaning
// IDLE    | no transaction; waiting for a strobe falling edge while selected
// WR      | nWE low; write issued on its rising edge
// RD      | nOE low; read latency timer running
// RD_HOLD | nOE low; read data latched and driven on the pads
module fsmc_slave_if
    import fsmc_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int AW          = AW_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nce,
    input  logic          noe,
    input  logic          nwe,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rd_stb,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          rd_done,
    output logic          err_overlap,
    output logic          err_abort,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    logic nce_s, nce_fall, nce_rise;
    logic noe_s, noe_fall, noe_rise;
    logic nwe_s, nwe_fall, nwe_rise;
    logic sync_unused;

    fsmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nce (
        .clk(clk), .reset(reset), .din(nce), .dout(nce_s), .fall(nce_fall), .rise(nce_rise));
    fsmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_noe (
        .clk(clk), .reset(reset), .din(noe), .dout(noe_s), .fall(noe_fall), .rise(noe_rise));
    fsmc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nwe (
        .clk(clk), .reset(reset), .din(nwe), .dout(nwe_s), .fall(nwe_fall), .rise(nwe_rise));

    // Chip select is used as a level only.
    assign sync_unused = nce_fall ^ nce_rise;

    // Address and data ride a pipeline of equal depth so they line up with
    // the synchronised strobes.
    logic [AW-1:0] addr_pipe [SYNC_STAGES];
    logic [DW-1:0] data_pipe [SYNC_STAGES];
    logic [AW-1:0] addr_s;
    logic [DW-1:0] data_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_pipe[i] <= '0;
                data_pipe[i] <= '0;
            end
        end else begin
            addr_pipe[0] <= addr;
            data_pipe[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign addr_s = addr_pipe[SYNC_STAGES-1];
    assign data_s = data_pipe[SYNC_STAGES-1];

    logic sel, overlap;
    assign sel     = ~nce_s;
    assign overlap = sel & ~noe_s & ~nwe_s;

    // After reset the synchroniser refills with pin samples; a strobe held
    // low across reset would then look like a fresh falling edge. New
    // transactions are only accepted once both strobes have been seen high
    // after the pipeline has refilled.
    logic              armed;
    logic [WARM_W-1:0] warm_cnt;
    logic [1:0]        lat_cnt;

    fsmc_state_e state, state_nxt;
    logic wr_stb_nxt, rd_stb_nxt, rd_done_nxt;
    logic lat_load, latch_rd, set_abort, set_overlap;

    always_comb begin
        state_nxt   = state;
        wr_stb_nxt  = 1'b0;
        rd_stb_nxt  = 1'b0;
        rd_done_nxt = 1'b0;
        lat_load    = 1'b0;
        latch_rd    = 1'b0;
        set_abort   = 1'b0;
        set_overlap = 1'b0;
        case (state)
            IDLE: begin
                if (overlap) begin
                    set_overlap = 1'b1;
                end else if (armed && sel && nwe_fall) begin
                    state_nxt = WR;
                end else if (armed && sel && noe_fall) begin
                    state_nxt  = RD;
                    rd_stb_nxt = 1'b1;
                    lat_load   = 1'b1;
                end
            end
            WR: begin
                if (!sel) begin
                    state_nxt = IDLE;
                    set_abort = 1'b1;
                end else if (overlap) begin
                    state_nxt   = IDLE;
                    set_overlap = 1'b1;
                end else if (nwe_rise) begin
                    state_nxt  = IDLE;
                    wr_stb_nxt = 1'b1;
                end
            end
            RD, RD_HOLD: begin
                if (!sel) begin
                    state_nxt = IDLE;
                    set_abort = 1'b1;
                end else if (overlap) begin
                    state_nxt   = IDLE;
                    set_overlap = 1'b1;
                end else if (noe_rise) begin
                    // An early release wins over a pending data latch.
                    state_nxt   = IDLE;
                    rd_done_nxt = 1'b1;
                end else if (state == RD && lat_cnt == 2'd0) begin
                    state_nxt = RD_HOLD;
                    latch_rd  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            rd_done     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_addr     <= '0;
            data_out    <= '0;
            err_overlap <= 1'b0;
            err_abort   <= 1'b0;
            wr_count    <= '0;
            rd_count    <= '0;
            lat_cnt     <= '0;
            armed       <= 1'b0;
            warm_cnt    <= WARM_W'(SYNC_STAGES);
        end else begin
            state   <= state_nxt;
            wr_stb  <= wr_stb_nxt;
            rd_stb  <= rd_stb_nxt;
            rd_done <= rd_done_nxt;
            if (wr_stb_nxt) begin
                wr_addr  <= addr_s;
                wr_data  <= data_s;
                wr_count <= wr_count + 16'd1;
            end
            if (rd_stb_nxt) begin
                rd_addr <= addr_s;
            end
            if (rd_done_nxt) begin
                rd_count <= rd_count + 16'd1;
            end
            if (latch_rd) begin
                data_out <= rd_data;
            end
            if (lat_load) begin
                lat_cnt <= 2'(RD_LAT);
            end else if (state == RD && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (set_abort) begin
                err_abort <= 1'b1;
            end
            if (set_overlap) begin
                err_overlap <= 1'b1;
            end
            if (warm_cnt != '0) begin
                warm_cnt <= warm_cnt - 1'b1;
            end else if (noe_s && nwe_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign data_oe = (state == RD || state == RD_HOLD) && !noe_s && sel;

endmodule

// File: tb/tb_fsmc_slave_if.sv
module tb_fsmc_slave_if;
    import fsmc_pkg::*;

    localparam int SYNC = 2;
    localparam int LAT  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        nce, noe, nwe;
    logic [1:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_stb;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_done;
    logic        err_overlap, err_abort;
    logic [15:0] wr_count, rd_count;

    fsmc_slave_if #(.DW(16), .AW(2), .SYNC_STAGES(SYNC), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .nce(nce), .noe(noe), .nwe(nwe), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
        .err_overlap(err_overlap), .err_abort(err_abort),
        .wr_count(wr_count), .rd_count(rd_count));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Consumer: fixed read-back contents, one cycle of latency.
    logic [15:0] rd_mem [4];
    initial begin
        rd_mem[0] = 16'h1234;
        rd_mem[1] = 16'h5678;
        rd_mem[2] = 16'h9ABC;
        rd_mem[3] = 16'hDEF0;
    end
    always @(posedge clk) if (rd_stb) rd_data <= rd_mem[rd_addr];

    typedef struct {
        logic [1:0]  a;
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t exp_wr[$];
    exp_t exp_rs[$];
    exp_t exp_rd[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    exp_t e;
    logic prev_wr = 1'b0, prev_rs = 1'b0, prev_rd = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_stb || rd_stb || rd_done) begin
                chk("strobe_onehot", 32'(wr_stb) + 32'(rd_stb) + 32'(rd_done), 32'd1);
                chk("strobe_repeat", 32'({wr_stb & prev_wr, rd_stb & prev_rs, rd_done & prev_rd}), 32'd0);
            end
            if (wr_stb) begin
                if (exp_wr.size() == 0) chk("wr_stb_unexpected", 32'(wr_stb), 32'd0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                    chk("wr_latency", 32'(cyc), 32'(e.c));
                end
            end
            if (rd_stb) begin
                if (exp_rs.size() == 0) chk("rd_stb_unexpected", 32'(rd_stb), 32'd0);
                else begin
                    e = exp_rs.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(e.a));
                    chk("rd_latency", 32'(cyc), 32'(e.c));
                end
            end
            if (rd_done) begin
                if (exp_rd.size() == 0) chk("rd_done_unexpected", 32'(rd_done), 32'd0);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_done_data_out", 32'(data_out), 32'(e.d));
                    chk("rd_done_data_oe", 32'(data_oe), 32'd0);
                    chk("rd_done_latency", 32'(cyc), 32'(e.c));
                end
            end
        end
        prev_wr = wr_stb;
        prev_rs = rd_stb;
        prev_rd = rd_done;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_data_oe"}, 32'(data_oe), 32'd0);
        chk({tag, "_strobes"}, 32'({wr_stb, rd_stb, rd_done}), 32'd0);
        chk({tag, "_errors"}, 32'({err_overlap, err_abort}), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(6);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        exp_t x;
        nce = 1'b0; addr = a; data_in = d;
        tick(1);
        nwe = 1'b0;
        tick(6);
        nwe = 1'b1;
        x.a = a; x.d = d; x.c = cyc + SYNC + 1;
        exp_wr.push_back(x);
        tick(5);
        nce = 1'b1;
        tick(2);
    endtask

    task automatic do_read(input logic [1:0] a, input logic [15:0] d);
        exp_t x;
        nce = 1'b0; addr = a;
        tick(1);
        noe = 1'b0;
        x.a = a; x.d = d; x.c = cyc + SYNC + 1;
        exp_rs.push_back(x);
        tick(6);
        chk("read_data_oe_high", 32'(data_oe), 32'd1);
        chk("read_data_out", 32'(data_out), 32'(d));
        tick(2);
        noe = 1'b1;
        x.c = cyc + SYNC + 1;
        exp_rd.push_back(x);
        tick(SYNC + 1);
        chk("read_data_oe_low", 32'(data_oe), 32'd0);
        tick(2);
        nce = 1'b1;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; nce = 1'b1; noe = 1'b1; nwe = 1'b1;
        addr = '0; data_in = '0; rd_data = '0;
        tick(3);
        chk_all_zero("por");
        reset = 1'b0;
        tick(6);

        // 1: single write
        do_write(ADDR_DATA, 16'hA55A);
        chk("t1_wr_count", 32'(wr_count), 32'd1);

        // 2: single read
        do_read(ADDR_DATA, 16'h1234);
        chk("t2_rd_count", 32'(rd_count), 32'd1);

        // 3: back-to-back, from a clean reset so counters read 4/4
        do_reset();
        do_write(ADDR_DATA, 16'h1111);
        do_write(ADDR_INDEX, 16'h0002);
        do_write(2'd1, 16'hBEEF);
        do_write(2'd3, 16'hC0DE);
        do_read(2'd3, 16'hDEF0);
        do_read(ADDR_INDEX, 16'h9ABC);
        do_read(2'd1, 16'h5678);
        do_read(ADDR_DATA, 16'h1234);
        chk("t3_wr_count", 32'(wr_count), 32'd4);
        chk("t3_rd_count", 32'(rd_count), 32'd4);
        chk("t3_errors", 32'({err_overlap, err_abort}), 32'd0);

        // 4: chip select lost mid-write
        nce = 1'b0; addr = 2'd1; data_in = 16'h7777;
        tick(1);
        nwe = 1'b0;
        tick(5);
        nce = 1'b1;
        tick(5);
        nwe = 1'b1;
        tick(6);
        chk("t4_err_abort", 32'(err_abort), 32'd1);
        chk("t4_wr_count", 32'(wr_count), 32'd4);
        chk("t4_err_overlap", 32'(err_overlap), 32'd0);
        tick(10);
        chk("t4_err_abort_sticky", 32'(err_abort), 32'd1);

        // 5: noe and nwe low together
        nce = 1'b0;
        tick(2);
        noe = 1'b0; nwe = 1'b0;
        tick(6);
        chk("t5_err_overlap", 32'(err_overlap), 32'd1);
        chk("t5_data_oe", 32'(data_oe), 32'd0);
        noe = 1'b1; nwe = 1'b1;
        tick(4);
        nce = 1'b1;
        tick(2);
        chk("t5_counts", 32'({wr_count, rd_count}), {16'd4, 16'd4});

        // 6: reset in the middle of a read
        nce = 1'b0; addr = 2'd1;
        tick(1);
        noe = 1'b0;
        begin
            exp_t x;
            x.a = 2'd1; x.d = 16'h5678; x.c = cyc + SYNC + 1;
            exp_rs.push_back(x);
        end
        tick(6);
        chk("t6_oe_before_reset", 32'(data_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_all_zero("t6");
        tick(3);
        noe = 1'b1;
        tick(4);
        nce = 1'b1;
        tick(4);
        chk("t6_no_rd_done_count", 32'(rd_count), 32'd0);
        do_read(ADDR_INDEX, 16'h9ABC);
        chk("t6_rd_count", 32'(rd_count), 32'd1);
        chk("t6_wr_count", 32'(wr_count), 32'd0);

        tick(5);
        chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("sb_rs_empty", 32'(exp_rs.size()), 32'd0);
        chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
